canvas_streamer: RTL and testbench
==================================

# canvas_streamer

Pixel canvas that sits between the mouse-drawing front end and the digit classifier. Stores the 32x32 one-bit drawing, accepts paint writes from the cursor logic, and serves a registered read port to the VGA pixel path. On command it streams the centred 28x28 crop, row-major, as 8-bit pixels over a valid/ready handshake to the DNN input stage.

## Interface
- C_DIM, 32, canvas edge length in pixels; address = Y*C_DIM + X
- C_CROP, 28, streamed crop edge length
- C_OFF, 2, crop origin offset in X and Y; crop covers 2..29
- C_ON_VAL, 8'hFF, byte emitted for a set pixel; a clear pixel emits 8'h00
- clkVga  in  1  pixel clock; all logic on its rising edge
- iRstN  in  1  reset, asynchronous, active-low
- iPaintEn  in  1  set pixel (iPaintX, iPaintY) to 1 this cycle
- iPaintX, iPaintY  in  5 each  paint coordinates
- iClear  in  1  request full-canvas clear
- iRdX, iRdY  in  5 each  display read address
- oRdPix  out  1  display read data
- iStart  in  1  request crop stream
- oData  out  8  stream pixel byte
- oValid  out  1  oData valid
- iReady  in  1  consumer accepts the beat
- oLast  out  1  marks beat 784, the final beat
- oBusy  out  1  high in CLEAR or STREAM
- oDone  out  1  one-cycle pulse after the final beat is accepted

## Operation
- Storage: 1024x1 bit array, not reset by iRstN; contents are defined only by the CLEAR sweep.
- FSM states: CLEAR, IDLE, STREAM, DONE.
- Reset: state=CLEAR with sweep counter 0; oValid=0, oLast=0, oDone=0, oData=0, oRdPix=0, oBusy=1.
- CLEAR: writes 0 to one address per cycle, 0 to 1023. After address 1023 is written, go to IDLE (1024 cycles).
- IDLE: iClear goes to CLEAR with counter 0. Otherwise, iStart goes to STREAM. When both are asserted, iClear wins and iStart is dropped. Neither request is queued.
- Paint: the write is accepted only in IDLE. In CLEAR, STREAM and DONE, iPaintEn is ignored, so the streamed image is a stable snapshot.
- STREAM:
  - Crop counters cy, cx each run 0..27, row-major with cx inner.
  - oData = C_ON_VAL if pixel[(cy+2)*32 + (cx+2)] is set, else 0.
  - A beat transfers on a rising edge with oValid && iReady. The counters advance only on a transfer.
  - While oValid && !iReady, oData and oLast hold stable and oValid stays high.
  - oLast = 1 exactly when cy=27 and cx=27.
  - Transfer of the oLast beat goes to DONE.
- DONE: one cycle, oDone=1, oValid=0. Then IDLE.
- iClear and iStart in STREAM and DONE are ignored.
- Display read port works in every state: oRdPix <= pixel[iRdY*32 + iRdX].
- Same-cycle read and write to one address returns the old value.

## Timing
- CLEAR lasts 1024 cycles after reset deassertion or after iClear is accepted. oBusy stays high throughout and drops on the edge entering IDLE.
- iStart sampled in IDLE at edge k:
  - oBusy=1 and oValid=1 from edge k, with beat 0 (crop pixel 2,2) presented.
  - With iReady held high, one beat per cycle, so 784 consecutive cycles.
  - oDone is high for the cycle after the last transfer.
  - Earliest next iStart is accepted 2 edges after the last transfer.
- Paint write at edge k is visible on oRdPix for a read address presented at edge k+1, with data at k+2. oRdPix latency is 1 cycle.
- oData is registered. The next pixel is prefetched so that back-to-back transfers have no bubble.
- Async reset mid-STREAM: oValid drops immediately and the FSM restarts in CLEAR. The consumer must discard the partial frame.

## Test plan
- Reset release: oBusy=1 for exactly 1024 cycles, then 0; read (31,31) gives oRdPix=0.
- Paint (2,2), (29,29) and (0,0), then stream with iReady=1:
  - beat 0 = 8'hFF, beat 783 = 8'hFF with oLast=1, all other beats 00.
  - (0,0) never appears in the stream.
  - oDone pulses one cycle after beat 783.
- Stream with iReady toggling 1,0,0,1 pattern: 784 transfers exactly, oData stable while stalled, no duplicate or skipped beat.
- iClear and iStart asserted together in IDLE: CLEAR taken (oValid stays 0, oBusy high 1024 cycles); a later stream returns all 00.
- iPaintEn at (10,10) during STREAM: stream unaffected, and post-stream read of (10,10) gives 0.
- Assert iRstN=0 at beat 300: oValid=0 immediately; after release a CLEAR sweep runs and a full 784-beat stream of zeros follows.

Source files
------------

// File: rtl/canvas_streamer.sv
// canvas_streamer: 32x32 one-bit drawing canvas with a paint port, a registered
// display read port, and a valid/ready stream of the centred 28x28 crop.
module canvas_streamer (
  input  logic       clkVga,
  input  logic       iRstN,
  input  logic       iPaintEn,
  input  logic [4:0] iPaintX,
  input  logic [4:0] iPaintY,
  input  logic       iClear,
  input  logic [4:0] iRdX,
  input  logic [4:0] iRdY,
  output logic       oRdPix,
  input  logic       iStart,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oLast,
  output logic       oBusy,
  output logic       oDone
);

  localparam int unsigned C_DIM   = 32;
  localparam int unsigned C_CROP  = 28;
  localparam int unsigned C_OFF   = 2;
  localparam int unsigned AW      = 10;
  localparam int unsigned CW      = 5;
  localparam logic [7:0]  C_ON_VAL = 8'hFF;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  // Canvas storage; contents are only ever defined by the clear sweep.
  logic mem [C_DIM*C_DIM];

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]   cx_q, cx_d;
  logic [CW-1:0]   cy_q, cy_d;
  logic            valid_d, last_d, done_d, busy_d;
  logic [7:0]      data_d;

  logic            we_c;
  logic [AW-1:0]   waddr_c;
  logic            wdata_c;

  // Canvas address of crop pixel (cx, cy).
  function automatic logic [AW-1:0] crop_addr(input logic [CW-1:0] cx,
                                              input logic [CW-1:0] cy);
    return {cy + CW'(C_OFF), cx + CW'(C_OFF)};
  endfunction

  // State, counters and registered stream outputs.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      oValid    <= 1'b0;
      oLast     <= 1'b0;
      oDone     <= 1'b0;
      oData     <= 8'h00;
      oBusy     <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      oValid    <= valid_d;
      oLast     <= last_d;
      oDone     <= done_d;
      oData     <= data_d;
      oBusy     <= busy_d;
    end
  end

  // Next state, canvas write port and next stream beat (prefetched on transfer).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    valid_d   = oValid;
    last_d    = oLast;
    done_d    = 1'b0;
    data_d    = oData;
    we_c      = 1'b0;
    waddr_c   = '0;
    wdata_c   = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        we_c      = 1'b1;
        waddr_c   = clr_cnt_q;
        wdata_c   = 1'b0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(C_DIM*C_DIM-1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (iPaintEn) begin
          we_c    = 1'b1;
          waddr_c = {iPaintY, iPaintX};
          wdata_c = 1'b1;
        end
        if (iClear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (iStart) begin
          state_d = ST_STREAM;
          cx_d    = '0;
          cy_d    = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
          data_d  = mem[crop_addr('0, '0)] ? C_ON_VAL : 8'h00;
        end
      end
      ST_STREAM: begin
        if (oValid && iReady) begin
          if (oLast) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = 8'h00;
          end else begin
            if (cx_q == CW'(C_CROP-1)) begin
              cx_d = '0;
              cy_d = cy_q + CW'(1);
            end else begin
              cx_d = cx_q + CW'(1);
            end
            valid_d = 1'b1;
            last_d  = (cx_d == CW'(C_CROP-1)) && (cy_d == CW'(C_CROP-1));
            data_d  = mem[crop_addr(cx_d, cy_d)] ? C_ON_VAL : 8'h00;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_STREAM);
  end

  // Single canvas write port (clear sweep or paint).
  always_ff @(posedge clkVga) begin
    if (we_c) begin
      mem[waddr_c] <= wdata_c;
    end
  end

  // Display read port; a same-cycle write is not forwarded.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      oRdPix <= 1'b0;
    end else begin
      oRdPix <= mem[{iRdY, iRdX}];
    end
  end

endmodule

// File: tb/tb_canvas_streamer.sv
// Bench for canvas_streamer: canvas model plus scoreboard of expected crop beats.
module tb_canvas_streamer;

  logic       clkVga;
  logic       iRstN;
  logic       iPaintEn;
  logic [4:0] iPaintX, iPaintY;
  logic       iClear;
  logic [4:0] iRdX, iRdY;
  logic       oRdPix;
  logic       iStart;
  logic [7:0] oData;
  logic       oValid;
  logic       iReady;
  logic       oLast;
  logic       oBusy;
  logic       oDone;

  canvas_streamer dut (
    .clkVga  (clkVga),
    .iRstN   (iRstN),
    .iPaintEn(iPaintEn),
    .iPaintX (iPaintX),
    .iPaintY (iPaintY),
    .iClear  (iClear),
    .iRdX    (iRdX),
    .iRdY    (iRdY),
    .oRdPix  (oRdPix),
    .iStart  (iStart),
    .oData   (oData),
    .oValid  (oValid),
    .iReady  (iReady),
    .oLast   (oLast),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int    vectors = 0;
  int    errors  = 0;
  beat_t exp_q[$];
  bit    model [32][32];
  int    beat_cnt = 0;
  bit    done_seen = 0;
  bit    done_exp = 0;
  bit    stalled = 0;
  logic [7:0] held_d;
  logic       held_l;
  int    rdy_mode = 0;
  int    rdy_cyc = 0;

  initial begin
    clkVga = 1'b0;
    forever #5 clkVga = ~clkVga;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clkVga);
    #1;
  endtask

  // Ready pattern: 0 = always, 1 = repeating 1,0,0,1, 2 = random.
  initial begin
    iReady = 1'b1;
    forever begin
      @(posedge clkVga);
      #1;
      rdy_cyc++;
      case (rdy_mode)
        1:       iReady = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
        2:       iReady = 1'($urandom_range(0, 1));
        default: iReady = 1'b1;
      endcase
    end
  end

  // Monitor: pops expected beats on every transfer, checks stall hold and oDone.
  always @(negedge clkVga) begin
    bit nxt_done;
    nxt_done = 0;
    if (!iRstN) begin
      exp_q.delete();
      stalled = 0;
      done_exp = 0;
    end else begin
      if (oDone === 1'b1 || done_exp) begin
        check("done_pulse", 32'(oDone), 32'(done_exp));
        if (done_exp && oDone === 1'b1) done_seen = 1;
      end
      if (oValid === 1'b1) begin
        if (stalled) begin
          check("stall_data", 32'(oData), 32'(held_d));
          check("stall_last", 32'(oLast), 32'(held_l));
        end
        if (iReady) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h with empty scoreboard at %0t", oData, $time);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check($sformatf("beat%0d_data", beat_cnt), 32'(oData), 32'(e.d));
            check($sformatf("beat%0d_last", beat_cnt), 32'(oLast), 32'(e.l));
            if (e.l) nxt_done = 1;
          end
          beat_cnt++;
          stalled = 0;
        end else begin
          stalled = 1;
          held_d  = oData;
          held_l  = oLast;
        end
      end else begin
        stalled = 0;
      end
      done_exp = nxt_done;
    end
  end

  task automatic model_clear();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        model[y][x] = 0;
  endtask

  // Expected crop stream: rows 2..29, columns 2..29, row-major.
  task automatic push_frame();
    for (int cy = 0; cy < 28; cy++) begin
      for (int cx = 0; cx < 28; cx++) begin
        beat_t b;
        b.d = model[cy+2][cx+2] ? 8'hFF : 8'h00;
        b.l = (cy == 27) && (cx == 27);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (oBusy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'd1024);
  endtask

  task automatic paint(input int x, input int y, input bit accepted);
    tick();
    iPaintEn = 1'b1;
    iPaintX  = 5'(x);
    iPaintY  = 5'(y);
    tick();
    iPaintEn = 1'b0;
    if (accepted) model[y][x] = 1;
  endtask

  task automatic read_check(input string name, input int x, input int y);
    tick();
    iRdX = 5'(x);
    iRdY = 5'(y);
    tick();
    check(name, 32'(oRdPix), 32'(model[y][x]));
  endtask

  task automatic start_stream(input bit with_clear);
    tick();
    done_seen = 0;
    iStart = 1'b1;
    iClear = with_clear;
    if (with_clear) model_clear();
    else push_frame();
    tick();
    iStart = 1'b0;
    iClear = 1'b0;
    check("start_busy", 32'(oBusy), 32'd1);
    check("start_valid", 32'(oValid), with_clear ? 32'd0 : 32'd1);
  endtask

  task automatic wait_stream(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !done_seen) && n < 8000) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size() == 0 && done_seen), 32'd1);
    check({name, "_idle"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    int base, n;
    iRstN = 1'b0; iPaintEn = 1'b0; iPaintX = '0; iPaintY = '0;
    iClear = 1'b0; iStart = 1'b0; iRdX = '0; iRdY = '0;
    model_clear();
    repeat (3) tick();
    check("rst_busy", 32'(oBusy), 32'd1);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_last", 32'(oLast), 32'd0);
    check("rst_data", 32'(oData), 32'd0);
    check("rst_rdpix", 32'(oRdPix), 32'd0);
    tick();
    iRstN = 1'b1;
    count_busy("reset_clear_len");
    read_check("read_31_31", 31, 31);

    // Corner paints and read-back latency.
    paint(2, 2, 1);
    paint(29, 29, 1);
    paint(0, 0, 1);
    read_check("read_2_2", 2, 2);
    read_check("read_0_0", 0, 0);
    tick();
    iPaintEn = 1'b1; iPaintX = 5'd31; iPaintY = 5'd0;
    iRdX = 5'd31; iRdY = 5'd0;
    tick();
    iPaintEn = 1'b0;
    check("rd_wr_same_old", 32'(oRdPix), 32'd0);
    model[0][31] = 1;
    tick();
    check("rd_wr_same_new", 32'(oRdPix), 32'd1);

    rdy_mode = 0;
    start_stream(0);
    wait_stream("stream_corners");

    rdy_mode = 1;
    start_stream(0);
    wait_stream("stream_pattern");
    rdy_mode = 0;

    // Clear wins over start; paint during stream is ignored.
    start_stream(1);
    count_busy("clear_len");
    start_stream(0);
    repeat (5) tick();
    paint(10, 10, 0);
    wait_stream("stream_after_clear");
    read_check("read_10_10", 10, 10);

    // Random drawings with random consumer back-pressure.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(10, 40);
      for (int i = 0; i < n; i++) paint($urandom_range(0, 31), $urandom_range(0, 31), 1);
      for (int i = 0; i < 4; i++) read_check("read_rand", $urandom_range(0, 31), $urandom_range(0, 31));
      rdy_mode = 2;
      start_stream(0);
      wait_stream("stream_rand");
      rdy_mode = 0;
    end

    // Asynchronous reset in the middle of a stream.
    start_stream(0);
    base = beat_cnt;
    n = 0;
    while (beat_cnt < base + 300 && n < 5000) begin
      tick();
      n++;
    end
    check("beats_before_reset", 32'(beat_cnt - base), 32'd300);
    iRstN = 1'b0;
    #1;
    check("async_rst_valid", 32'(oValid), 32'd0);
    check("async_rst_busy", 32'(oBusy), 32'd1);
    repeat (3) tick();
    model_clear();
    iRstN = 1'b1;
    count_busy("rerst_clear_len");
    base = beat_cnt;
    start_stream(0);
    wait_stream("stream_after_reset");
    check("after_reset_beats", 32'(beat_cnt - base), 32'd784);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
